// File: rtl/uart_pkg.sv
// Constants, state encoding and helpers shared by the UART transmitter and receiver.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 16;
  localparam int unsigned DATA_BITS        = 8;
  localparam logic        IDLE_LEVEL       = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HI
  } rx_state_e;

  // Two-out-of-three vote over a sample window.
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus byte valid/accept handshake and error pulses of the UART receiver.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 i_rx;
  logic                 i_accept;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_frame_err;
  logic                 o_overrun;

  // Receiver side.
  modport slave (
    input  i_rx, i_accept,
    output o_data, o_valid, o_frame_err, o_overrun
  );

  // Line driver / byte consumer side.
  modport master (
    output i_rx, i_accept,
    input  o_data, o_valid, o_frame_err, o_overrun
  );

endinterface

// File: rtl/uart_rx_filter.sv
// Two-flop synchronizer followed by a registered 3-sample majority vote.
module uart_rx_filter
  import uart_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  output logic o_m
);

  logic [1:0] sync_q;
  logic [1:0] hist_q;
  logic       m_q;

  // Everything resets to the idle level so leaving reset never looks like a start bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= {2{IDLE_LEVEL}};
      hist_q <= {2{IDLE_LEVEL}};
      m_q    <= IDLE_LEVEL;
    end else begin
      sync_q <= {sync_q[0], i_rx};
      hist_q <= {hist_q[0], sync_q[1]};
      m_q    <= majority3({hist_q, sync_q[1]});
    end
  end

  assign o_m = m_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: filtered line, mid-bit sampling FSM, held output byte with error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic     i_clk,
  input  logic     i_rst,
  uart_rx_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic m;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  uart_rx_filter u_filter (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_rx  (bus.i_rx),
    .o_m   (m)
  );

  // State, counter, shift register and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Frame sequencing; the counter restarts from zero on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && bus.i_accept) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!m) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!m) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d          = '0;
          shift_d[idx_q] = m;
          if (idx_q == LAST_IDX) state_d = ST_STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d = '0;
          if (m) begin
            state_d = ST_IDLE;
            if (!valid_q || bus.i_accept) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HI;
          end
        end
      end
      ST_WAIT_HI: begin
        cnt_d = '0;
        if (m) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = ferr_q;
  assign bus.o_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected events, a monitor pops them as the DUT reports.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CPB = 16;
  // Edges from the first edge that samples the low start bit to the edge that raises o_valid:
  // 3 front-end flops to m, 1 IDLE detection, half a start bit, 8 data bits and the stop bit.
  localparam int LATENCY = 3 + 1 + CPB / 2 + 9 * CPB;

  typedef enum int {EV_DATA, EV_FERR, EV_OVR} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  int  accept_mode = 0;   // 0: high, 1: low, 2: random
  int  last_rise = 0;
  int  last_fall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input ev_kind_e k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_expect(input ev_kind_e k, input logic [7:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d data %0h expected none", k, d);
    end else begin
      e = exp_q.pop_front();
      checks--;
      check("event_kind", 32'(k), 32'(e.kind));
      if (e.kind == EV_DATA && k == EV_DATA) check("event_data", 32'(d), 32'(e.data));
    end
  endtask

  // Monitor and accept driver.
  logic       shown = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] cur = '0;
  always @(negedge clk) begin
    if (rst) begin
      shown      = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (bus.o_frame_err) pop_expect(EV_FERR, 8'h00);
      if (bus.o_overrun)   pop_expect(EV_OVR, 8'h00);
      if (bus.o_valid && !shown) begin
        pop_expect(EV_DATA, bus.o_data);
        cur   = bus.o_data;
        shown = 1'b1;
      end else if (bus.o_valid) begin
        check("data_hold", 32'(bus.o_data), 32'(cur));
      end
      if (bus.o_valid && !prev_valid) last_rise = cyc;
      if (!bus.o_valid && prev_valid) last_fall = cyc;
      prev_valid = bus.o_valid;
    end
    case (accept_mode)
      0:       bus.i_accept = 1'b1;
      1:       bus.i_accept = 1'b0;
      default: bus.i_accept = 1'($urandom_range(0, 1));
    endcase
    if (!rst && bus.o_valid && bus.i_accept) shown = 1'b0;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.i_rx = 1'b1;
    repeat (n) tick();
  endtask

  // Frame of 10 bits; bit boundaries placed at k*CPB*permille/1000 cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int permille);
    logic [9:0] bits;
    int prev;
    int nb;
    bits      = {stop_lvl, b, 1'b0};
    prev      = 0;
    start_cyc = cyc;
    for (int k = 1; k <= 10; k++) begin
      nb       = (k * int'(CPB) * permille + 500) / 1000;
      bus.i_rx = bits[k-1];
      repeat (nb - prev) tick();
      prev = nb;
    end
    bus.i_rx = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * CPB * 12) begin
      tick();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst_data",  32'(bus.o_data),      32'd0);
    check("rst_valid", 32'(bus.o_valid),     32'd0);
    check("rst_ferr",  32'(bus.o_frame_err), 32'd0);
    check("rst_ovr",   32'(bus.o_overrun),   32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int pm;
    rst      = 1'b1;
    bus.i_rx = 1'b1;
    repeat (3) tick();
    check_reset_outputs();
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst = 1'b0;
    idle(2 * CPB);

    // Single 0xA5 frame, accept high: exact latency and a one-cycle valid.
    accept_mode = 0;
    push(EV_DATA, 8'hA5);
    send_frame(8'hA5, 1'b1, 1000);
    idle(CPB);
    check("latency_a5", 32'(last_rise - start_cyc - 1), 32'(LATENCY));
    check("valid_width_a5", 32'(last_fall - last_rise), 32'd1);
    drain("drain_a5");

    // 1-cycle glitch then a 6-cycle low pulse: no byte, no flags.
    bus.i_rx = 1'b0;
    tick();
    idle(20);
    bus.i_rx = 1'b0;
    repeat (6) tick();
    idle(3 * CPB);
    check("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("glitch_valid", 32'(bus.o_valid), 32'd0);
    check("glitch_no_event", 32'(exp_q.size()), 32'd0);

    // Framing error, long break, then a good frame.
    push(EV_FERR, 8'h00);
    send_frame(8'h3C, 1'b0, 1000);
    bus.i_rx = 1'b0;
    repeat (40 * CPB) tick();
    idle(2 * CPB);
    push(EV_DATA, 8'h81);
    send_frame(8'h81, 1'b1, 1000);
    idle(CPB);
    drain("drain_ferr");

    // Overrun: two frames while the consumer stalls, then a single accept.
    accept_mode = 1;
    idle(2);
    push(EV_DATA, 8'h11);
    push(EV_OVR, 8'h00);
    send_frame(8'h11, 1'b1, 1000);
    send_frame(8'h22, 1'b1, 1000);
    idle(CPB);
    check("ovr_valid_held", 32'(bus.o_valid), 32'd1);
    check("ovr_data_kept", 32'(bus.o_data), 32'h11);
    accept_mode = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.i_accept && bus.o_valid) break;
    end
    tick();
    check("ovr_valid_falls", 32'(bus.o_valid), 32'd0);
    drain("drain_ovr");

    // Back-to-back frames at +/-3% baud.
    push(EV_DATA, 8'h00);
    push(EV_DATA, 8'hFF);
    push(EV_DATA, 8'h55);
    send_frame(8'h00, 1'b1, 1030);
    send_frame(8'hFF, 1'b1, 970);
    send_frame(8'h55, 1'b1, 1030);
    idle(CPB);
    drain("drain_baud");

    // Reset in the middle of the data bits of 0x5A, then 0xC3.
    b        = 8'h5A;
    bus.i_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 3; i++) begin
      bus.i_rx = b[i];
      repeat (CPB) tick();
    end
    rst      = 1'b1;
    bus.i_rx = 1'b1;
    repeat (3) tick();
    check_reset_outputs();
    rst = 1'b0;
    idle(3 * CPB);
    check("post_rst_valid", 32'(bus.o_valid), 32'd0);
    push(EV_DATA, 8'hC3);
    send_frame(8'hC3, 1'b1, 1000);
    idle(CPB);
    drain("drain_rst");

    // Random bytes, baud error and gaps with a randomly stalling consumer.
    accept_mode = 2;
    for (int n = 0; n < 20; n++) begin
      b  = 8'($urandom_range(0, 255));
      pm = int'($urandom_range(970, 1030));
      push(EV_DATA, b);
      send_frame(b, 1'b1, pm);
      idle(int'($urandom_range(0, 2 * CPB)));
    end
    idle(2 * CPB);
    drain("drain_random");

    accept_mode = 0;
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
